// File: rtl/scan_mux_pkg.sv
// Shared constants for the scan multiplexer: mode encoding and default geometry.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 1;
    localparam int DEF_DWELL    = 4;

endpackage

// File: rtl/scan_mux_dwell.sv
// Dwell counter for auto-scan: counts 0..DWELL-1 while enabled, tick on the last count.
module scan_mux_dwell
    import scan_mux_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A one-cycle dwell still needs a 1-bit counter that simply stays at 0.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick = en && !clr && (count_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Channel scan multiplexer with manual select and timed auto-scan.
// Optional SCAN_MUX_HOLD_EN adds a hold input that freezes auto-scan.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DWELL    = DEF_DWELL,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           select,
    input  logic [CHANNELS*WIDTH-1:0] c,
    output logic [WIDTH-1:0]          led,
    output logic [SELW-1:0]           chan,
    output logic                      wrap
`ifdef SCAN_MUX_HOLD_EN
    ,
    input  logic                      hold
`endif
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
    localparam logic [SELW:0]   CH_LIM  = (SELW + 1)'(CHANNELS);

    logic                  frozen;
    logic                  auto_mode;
    logic                  tick;
    logic [SELW-1:0]       select_clamped;
    logic [WIDTH-1:0]      ch_data [CHANNELS];

    logic [SELW-1:0]       chan_reg;
    logic [SELW-1:0]       chan_next;
    logic [WIDTH-1:0]      led_reg;
    logic [WIDTH-1:0]      led_next;
    logic                  wrap_reg;
    logic                  wrap_next;

`ifdef SCAN_MUX_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    assign auto_mode = (mode == MODE_AUTO);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign ch_data[gi] = c[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Manual mode keeps the counter cleared, so entering auto starts a full dwell.
    scan_mux_dwell #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .en   (auto_mode && !frozen),
        .clr  (!auto_mode),
        .tick (tick)
    );

    assign select_clamped = ({1'b0, select} >= CH_LIM) ? LAST_CH : select;

    always_comb begin
        chan_next = chan_reg;
        wrap_next = 1'b0;
        led_next  = ch_data[chan_reg];
        if (!auto_mode) begin
            chan_next = select_clamped;
        end else if (tick) begin
            if (chan_reg == LAST_CH) begin
                chan_next = '0;
                wrap_next = 1'b1;
            end else begin
                chan_next = chan_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_reg <= '0;
            led_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            chan_reg <= chan_next;
            led_reg  <= led_next;
            wrap_reg <= wrap_next;
        end
    end

    assign chan = chan_reg;
    assign led  = led_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: reference model feeds a scoreboard queue,
// plus directed checks on a 3-channel, 3-bit-wide instance.
module tb_scan_mux;

    localparam int CH = 4;
    localparam int W  = 1;
    localparam int DW = 3;

    typedef struct {
        string      tag;
        logic [1:0] chan;
        logic       led;
        logic       wrap;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [1:0] select;
    logic [3:0] c;
    logic       hold;
    logic       led;
    logic [1:0] chan;
    logic       wrap;

    logic       mode2;
    logic [1:0] select2;
    logic [8:0] c2;
    logic       hold2;
    logic [2:0] led2;
    logic [1:0] chan2;
    logic       wrap2;

    int n_cmp;
    int n_bad;

    int m_chan;
    int m_cnt;
    exp_t sb[$];

    scan_mux #(.CHANNELS(CH), .WIDTH(W), .DWELL(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .select (select),
        .c      (c),
        .led    (led),
        .chan   (chan),
        .wrap   (wrap)
`ifdef SCAN_MUX_HOLD_EN
        ,
        .hold   (hold)
`endif
    );

    scan_mux #(.CHANNELS(3), .WIDTH(3), .DWELL(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode2),
        .select (select2),
        .c      (c2),
        .led    (led2),
        .chan   (chan2),
        .wrap   (wrap2)
`ifdef SCAN_MUX_HOLD_EN
        ,
        .hold   (hold2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model from the inputs currently applied, push the
    // expectation, clock the DUT, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        int   n_chan;
        int   n_cnt;
        e.tag  = tag;
        e.led  = c[m_chan];
        e.wrap = 1'b0;
        n_chan = m_chan;
        n_cnt  = m_cnt;
        if (mode == 1'b0) begin
            n_chan = (int'(select) >= CH) ? CH - 1 : int'(select);
            n_cnt  = 0;
        end else if (hold == 1'b1) begin
            n_chan = m_chan;
            n_cnt  = m_cnt;
`ifndef SCAN_MUX_HOLD_EN
            n_cnt  = (m_cnt == DW - 1) ? 0 : m_cnt + 1;
`endif
        end else if (m_cnt == DW - 1) begin
            n_cnt  = 0;
            n_chan = (m_chan + 1) % CH;
            e.wrap = (n_chan == 0);
        end else begin
            n_cnt  = m_cnt + 1;
        end
        e.chan = n_chan[1:0];
        m_chan = n_chan;
        m_cnt  = n_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, "_chan"}, 32'(chan), 32'(got.chan));
        check({got.tag, "_led"},  32'(led),  32'(got.led));
        check({got.tag, "_wrap"}, 32'(wrap), 32'(got.wrap));
        $display("step %-8s chan=%0d led=%0b wrap=%0b chan2=%0d led2=%0h wrap2=%0b",
                 got.tag, chan, led, wrap, chan2, led2, wrap2);
    endtask

    initial begin
        int auto_tbl[12];
        auto_tbl = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        n_cmp   = 0;
        n_bad   = 0;
        m_chan  = 0;
        m_cnt   = 0;
        rst     = 1'b1;
        mode    = 1'b0;
        select  = 2'd0;
        c       = 4'b0100;
        hold    = 1'b0;
        mode2   = 1'b0;
        select2 = 2'd0;
        c2      = {3'b101, 3'b010, 3'b111};
        hold2   = 1'b0;

        #3;
        check("rst0_chan", 32'(chan), 32'd0);
        check("rst0_led",  32'(led),  32'd0);
        check("rst0_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Manual: select 0 -> 2, chan follows after one edge, led after two.
        step("man0");
        select = 2'd2;
        step("man_t1");
        check("man_chan2", 32'(chan), 32'd2);
        step("man_t2");
        check("man_led1", 32'(led), 32'd1);
        c = 4'b1011;
        select = 2'd3;
        step("man_c");
        step("man_s3");

        // Asynchronous reset between edges clears everything at once.
        rst = 1'b1;
        #2;
        check("arst_chan", 32'(chan), 32'd0);
        check("arst_led",  32'(led),  32'd0);
        check("arst_wrap", 32'(wrap), 32'd0);
        m_chan = 0;
        m_cnt  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Auto scan from channel 0 with DWELL=3.
        mode = 1'b1;
        c    = 4'b1010;
        for (int i = 0; i < 12; i++) begin
            step("auto");
            check("auto_tbl",  32'(chan), 32'(auto_tbl[i]));
            check("auto_wrpt", 32'(wrap), (i == 11) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) step("auto2");

        // Mid-dwell on channel 1: drop to manual with select=3, then back to auto.
        mode   = 1'b0;
        select = 2'd3;
        step("sw_man");
        check("sw_man_chan", 32'(chan), 32'd3);
        mode = 1'b1;
        for (int i = 0; i < 4; i++) step("sw_auto");

`ifdef SCAN_MUX_HOLD_EN
        step("pre_hold");
        hold = 1'b1;
        for (int i = 0; i < 5; i++) step("hold");
        hold = 1'b0;
        for (int i = 0; i < 5; i++) step("post_hold");
        mode = 1'b0;
        hold = 1'b1;
        select = 2'd1;
        step("hold_man");
        hold = 1'b0;
        mode = 1'b1;
`endif

        // Reset released mid-scan restarts from channel 0 with a full dwell.
        step("pre_rst");
        rst = 1'b1;
        #2;
        m_chan = 0;
        m_cnt  = 0;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step("rst_scan");

        // 3-channel instance: clamp, led width, non-power-of-two wrap.
        mode    = 1'b0;
        select  = 2'd0;
        select2 = 2'd3;
        step("c3_a");
        check("c3_clamp", 32'(chan2), 32'd2);
        step("c3_b");
        check("c3_led_ch2", 32'(led2), 32'h5);
        select2 = 2'd1;
        step("c3_c");
        check("c3_chan1", 32'(chan2), 32'd1);
        step("c3_d");
        check("c3_led_ch1", 32'(led2), 32'h2);
        mode2 = 1'b1;
        step("c3_e");
        check("c3_dwell_chan", 32'(chan2), 32'd1);
        step("c3_f");
        check("c3_adv_chan", 32'(chan2), 32'd2);
        check("c3_adv_wrap", 32'(wrap2), 32'd0);
        step("c3_g");
        check("c3_g_chan", 32'(chan2), 32'd2);
        step("c3_h");
        check("c3_wrap_chan", 32'(chan2), 32'd0);
        check("c3_wrap_pulse", 32'(wrap2), 32'd1);
        check("c3_wrap_led", 32'(led2), 32'h5);
        step("c3_i");
        check("c3_after_wrap", 32'(wrap2), 32'd0);
        check("c3_led_ch0", 32'(led2), 32'h7);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
